// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, ALU control codes and the requester tag.
// Imported by the arbiter top and its grant sub-module.
package alu_pkg;

  localparam int ALU_WIDTH  = 32;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

  typedef enum logic {
    TAG_REQ0 = 1'b0,
    TAG_REQ1 = 1'b1
  } req_tag_t;

endpackage

// File: rtl/alu_arb_grant.sv
// Two-input grant logic for the shared ALU. ALU_ARB_RR_EN selects round-robin
// (with a priority pointer); otherwise requester 0 has fixed priority.
module alu_arb_grant
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

`ifdef ALU_ARB_RR_EN
  // Pointer names the requester served most recently; reset favours requester 0.
  req_tag_t last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= TAG_REQ1;
    end else if (accept) begin
      last <= grant[1] ? TAG_REQ1 : TAG_REQ0;
    end
  end

  always_comb begin
    grant = valid;
    if (&valid) begin
      grant = (last == TAG_REQ1) ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_ctl;
  assign unused_ctl = ^{clk, rst_n, accept};
  assign grant      = {valid[1] & ~valid[0], valid[0]};
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates the shared ALU between two requesters: issue register feeding the ALU,
// then one response slot per requester. Grant policy set by ALU_ARB_RR_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic              rsp0_zero,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic              rsp1_zero,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero
);

  logic [1:0] grant;
  logic       slot_free0, slot_free1;
  logic       s1_valid;
  req_tag_t   s1_tag;
  logic       s1_adv;
  logic       accept;
  logic       load0, load1;

  assign slot_free0 = !rsp0_valid || rsp0_ready;
  assign slot_free1 = !rsp1_valid || rsp1_ready;
  assign s1_adv     = !s1_valid || ((s1_tag == TAG_REQ1) ? slot_free1 : slot_free0);

  assign req0_ready = grant[0] && s1_adv;
  assign req1_ready = grant[1] && s1_adv;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign load0 = s1_valid && (s1_tag == TAG_REQ0) && slot_free0;
  assign load1 = s1_valid && (s1_tag == TAG_REQ1) && slot_free1;

  alu_arb_grant u_grant (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Stage 1: issue register driving the ALU; operands hold when the stage empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_tag   <= TAG_REQ0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_tag   <= grant[1] ? TAG_REQ1 : TAG_REQ0;
      alu_a    <= grant[1] ? req1_a    : req0_a;
      alu_b    <= grant[1] ? req1_b    : req0_b;
      alu_ctrl <= grant[1] ? req1_ctrl : req0_ctrl;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: per-requester response slots; a load wins over a same-cycle drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
    end else if (load0) begin
      rsp0_valid  <= 1'b1;
      rsp0_result <= alu_result;
      rsp0_zero   <= alu_zero;
    end else if (rsp0_ready) begin
      rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else if (load1) begin
      rsp1_valid  <= 1'b1;
      rsp1_result <= alu_result;
      rsp1_zero   <= alu_zero;
    end else if (rsp1_ready) begin
      rsp1_valid  <= 1'b0;
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and issue pipeline that shares the single 32-bit ALU between the main datapath (requester 0) and an auxiliary unit (requester 1). It grants one request per cycle, registers the winning operands and control code onto the ALU inputs, then captures `Resultado`/`Zero` into a per-requester response slot with valid/ready backpressure. It sits between the requesters and the ALU instance and does not decode `ALUControl`.

## Interface
- `WIDTH`, 32: operand/result width.
- `CTRL_W`, 4: ALU control code width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  request present.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle when high with valid.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_ctrl` / `req1_ctrl`  in  CTRL_W  ALU control code, forwarded unchanged.
- `rsp0_valid` / `rsp1_valid`  out  1  response slot full.
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes response.
- `rsp0_result` / `rsp1_result`  out  WIDTH  captured ALU result.
- `rsp0_zero` / `rsp1_zero`  out  1  captured zero flag.
- `alu_a`, `alu_b`  out  WIDTH  to ALU inputs A/B.
- `alu_ctrl`  out  CTRL_W  to ALU control.
- `alu_result`  in  WIDTH  from ALU result.
- `alu_zero`  in  1  from ALU zero flag.

## Operation
- Stage 1 (issue register): `s1_valid`, `s1_tag` (0/1), `alu_a`, `alu_b`, `alu_ctrl`. Stage 2: two response slots, one per requester.
- `slot_free[k] = !rspk_valid || rspk_ready`; `s1_adv = !s1_valid || slot_free[s1_tag]`.
- Grant computed combinationally from valids; `reqk_ready = grant[k] && s1_adv`. At most one ready high per cycle; ready never high without the matching valid.
- On accept: stage 1 loads operands, ctrl, tag; `s1_valid`=1. If `s1_adv` and no accept: `s1_valid`=0, `alu_*` hold last values.
- When `s1_valid && slot_free[s1_tag]`: slot `s1_tag` loads `alu_result`, `alu_zero`; `rsp_valid`=1.
- Slot k clears when `rspk_ready` high and no new load into it; simultaneous drain and load → new data, valid stays 1.
- Stall: if slot `s1_tag` full and not drained, stage 1 holds, both readys low; other requester's slot still drains.
- Grant policy per Configuration. Priority pointer `last` updates only on an accepted handshake.
- Reset (any time, including mid-transaction): in-flight request and responses discarded, no response emitted for them.

## Timing
- Reset values: all `*_ready`, `*_valid`, `rsp*_zero` 0; `rsp*_result`, `alu_a`, `alu_b`, `alu_ctrl` 0; `last` = 1 (requester 0 first).
- Latency: accept at edge N → `alu_*` valid in cycle N+1 → `rspk_valid` high in cycle N+2.
- Throughput: one request per cycle when responses drain every cycle.
- Readys depend combinationally on valids and `rsp*_ready`; no combinational path from `req*_a/b/ctrl` to any output.
- `alu_result`/`alu_zero` must settle within cycle N+1 (ALU is purely combinational).

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin — with both valid, grant the requester not equal to `last`; single valid always granted.
- Not defined: fixed priority — requester 0 always wins; requester 1 granted only when `req0_valid`=0; `last` register not instantiated.

## Structure
- Shared package `alu_pkg`: `WIDTH`/`CTRL_W` constants, ALU control code constants (ADD 4'b0010, SUB 4'b0110, AND 4'b0000, OR 4'b0001, NOR 4'b1100, ...), requester tag type.
- One sub-module `alu_arb_grant`: two-input grant logic (round-robin or fixed per macro), outputs `grant[1:0]`, updates `last`.

## Test plan
- Single req0 ADD a=5,b=7 at cycle 0 → `alu_ctrl`=0010 cycle 1; `rsp0_valid`=1, `rsp0_result`=12, `rsp0_zero`=0 cycle 2.
- req1 SUB a=9,b=9 → `rsp1_result`=0, `rsp1_zero`=1, `rsp0_valid` stays 0.
- Both valid continuously, RR_EN defined → grants 0,1,0,1; undefined → all grants to 0, `req1_ready` never 1.
- `rsp0_ready`=0 with slot 0 full, new req0 accepted → stage 1 holds, both readys 0; raising `rsp0_ready` → old result drains, new result lands next edge, no loss or duplication.
- Back-to-back 8 req0 ops, `rsp0_ready`=1 → 8 responses in order on consecutive cycles.
- `rst_n` low while stage 1 and slot 1 valid → all valids 0 immediately; after release no stale response appears.
